// File: rtl/sram_1r1w_bwe_model_if.sv
// Port bundle for the 1R1W bit-masked SRAM model. Signal names and active-low
// polarities match the hard macros that will replace the model.
interface sram_1r1w_bwe_model_if #(
    parameter int unsigned Bits      = 64,
    parameter int unsigned Add_Width = 9
);
    logic                 REB;
    logic                 WEB;
    logic [Add_Width-1:0] AA;
    logic [Add_Width-1:0] AB;
    logic [Bits-1:0]      D;
    logic [Bits-1:0]      BWEB;
    logic [Bits-1:0]      Q;
    logic                 INIT_DONE;

    modport master (output REB, WEB, AA, AB, D, BWEB, input Q, INIT_DONE);
    modport slave  (input REB, WEB, AA, AB, D, BWEB, output Q, INIT_DONE);
endinterface

// File: rtl/sram_1r1w_bwe_model.sv
// Behavioural 1R1W SRAM with per-bit write mask, 1/2-cycle read latency and a
// post-reset clear sweep. Define SRAM_MODEL_RANDOM_IDLE_EN to scramble Q on idle cycles.
module sram_1r1w_bwe_model #(
    parameter int unsigned Bits         = 64,
    parameter int unsigned Word_Depth   = 512,
    parameter int unsigned Add_Width    = 9,
    parameter int unsigned Read_Latency = 1
) (
    input logic                  CLK,
    input logic                  RSTB,
    sram_1r1w_bwe_model_if.slave bus
);
    if (Read_Latency != 1 && Read_Latency != 2) begin : g_bad_latency
        $fatal(1, "sram_1r1w_bwe_model: Read_Latency must be 1 or 2");
    end
    if ((64'd1 << Add_Width) < 64'(Word_Depth)) begin : g_bad_width
        $fatal(1, "sram_1r1w_bwe_model: Add_Width too small for Word_Depth");
    end

    localparam logic [Add_Width-1:0] LastAddr = Add_Width'(Word_Depth - 1);

    typedef enum logic {StInit, StReady} state_e;

    state_e               state_q, state_d;
    logic [Add_Width-1:0] cnt_q, cnt_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [Bits-1:0]      s1_data_q, s1_data_d;
    logic [Bits-1:0]      q_q, q_d;

    logic [Bits-1:0]      mem_q [Word_Depth];
    logic                 mem_we;
    logic [Add_Width-1:0] mem_addr;
    logic [Bits-1:0]      mem_wdata, mem_wmask;

    logic            wr_in_range, rd_in_range;
    logic [Bits-1:0] rd_word, idle_q;

    assign wr_in_range = 32'(bus.AA) < Word_Depth;
    assign rd_in_range = 32'(bus.AB) < Word_Depth;
    // Sampled before this edge's write lands, giving read-before-write on collisions.
    assign rd_word     = rd_in_range ? mem_q[bus.AB] : '0;

`ifdef SRAM_MODEL_RANDOM_IDLE_EN
    localparam int unsigned RandWords = (Bits + 31) / 32;
    logic [RandWords*32-1:0] rand_q;

    always_ff @(posedge CLK) begin
        for (int i = 0; i < RandWords; i++) begin
            rand_q[i*32 +: 32] <= $random;
        end
    end
    assign idle_q = rand_q[Bits-1:0];
`else
    assign idle_q = q_q;
`endif

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.AA;
        mem_wdata = bus.D;
        mem_wmask = ~bus.BWEB;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_addr  = cnt_q;
            mem_wdata = '0;
            mem_wmask = '1;
        end else if (!bus.WEB && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s1_vld_d  = 1'b0;
        s1_data_d = s1_data_q;
        q_d       = q_q;
        unique case (state_q)
            StInit: begin
                q_d   = '0;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastAddr) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end
            end
            StReady: begin
                if (Read_Latency == 1) begin
                    q_d = !bus.REB ? rd_word : idle_q;
                end else begin
                    s1_vld_d = !bus.REB;
                    if (!bus.REB) s1_data_d = rd_word;
                    q_d = s1_vld_q ? s1_data_q : idle_q;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_data_q <= s1_data_d;
            q_q       <= q_d;
        end
    end

    // Contents are never reset; only the sweep clears them.
    always_ff @(posedge CLK) begin
        if (RSTB && mem_we) begin
            mem_q[mem_addr] <= (mem_q[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        end
    end

    assign bus.Q         = q_q;
    assign bus.INIT_DONE = (state_q == StReady);

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RSTB && state_q == StReady) begin
            if (!bus.WEB && !wr_in_range)
                $display("%m warning: write to out-of-range address %0d dropped", bus.AA);
            if (!bus.REB && !rd_in_range)
                $display("%m warning: read of out-of-range address %0d returns zero", bus.AB);
        end
    end
`endif
endmodule

// File: tb/tb_sram_1r1w_bwe_model.sv
// Scoreboard bench for sram_1r1w_bwe_model: dut_a is 512 words / latency 1,
// dut_b is 500 words / latency 2.
module tb_sram_1r1w_bwe_model;
    localparam int unsigned Bits   = 64;
    localparam int unsigned AddW   = 9;
    localparam int unsigned DepthA = 512;
    localparam int unsigned DepthB = 500;

    typedef struct {
        logic [Bits-1:0] data;
        int              due;
    } exp_t;

    logic clk = 1'b0;
    logic rstb_a, rstb_b;
    always #5 clk = ~clk;

    sram_1r1w_bwe_model_if #(.Bits(Bits), .Add_Width(AddW)) bus_a ();
    sram_1r1w_bwe_model_if #(.Bits(Bits), .Add_Width(AddW)) bus_b ();

    sram_1r1w_bwe_model #(
        .Bits(Bits), .Word_Depth(DepthA), .Add_Width(AddW), .Read_Latency(1)
    ) u_dut_a (
        .CLK (clk),
        .RSTB(rstb_a),
        .bus (bus_a)
    );

    sram_1r1w_bwe_model #(
        .Bits(Bits), .Word_Depth(DepthB), .Add_Width(AddW), .Read_Latency(2)
    ) u_dut_b (
        .CLK (clk),
        .RSTB(rstb_b),
        .bus (bus_b)
    );

    exp_t            sb_a[$];
    exp_t            sb_b[$];
    exp_t            e;
    logic [Bits-1:0] model_a [DepthA];
    logic [Bits-1:0] model_b [DepthB];
    int              cyc      = 0;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_ab();
        bus_a.REB = 1'b1; bus_a.WEB = 1'b1;
        bus_b.REB = 1'b1; bus_b.WEB = 1'b1;
    endtask

    // Call rd_* before wr_* in the same cycle so the expectation sees old data.
    task automatic rd_a(input int unsigned addr);
        exp_t n;
        bus_a.REB = 1'b0;
        bus_a.AB  = AddW'(addr);
        n.data    = model_a[addr];
        n.due     = cyc + 1;
        sb_a.push_back(n);
    endtask

    task automatic wr_a(input int unsigned addr, input logic [Bits-1:0] d,
                        input logic [Bits-1:0] bweb);
        bus_a.WEB  = 1'b0;
        bus_a.AA   = AddW'(addr);
        bus_a.D    = d;
        bus_a.BWEB = bweb;
        model_a[addr] = (model_a[addr] & bweb) | (d & ~bweb);
    endtask

    task automatic rd_b(input int unsigned addr);
        exp_t n;
        bus_b.REB = 1'b0;
        bus_b.AB  = AddW'(addr);
        n.data    = (addr < DepthB) ? model_b[addr] : '0;
        n.due     = cyc + 2;
        sb_b.push_back(n);
    endtask

    task automatic wr_b(input int unsigned addr, input logic [Bits-1:0] d,
                        input logic [Bits-1:0] bweb);
        bus_b.WEB  = 1'b0;
        bus_b.AA   = AddW'(addr);
        bus_b.D    = d;
        bus_b.BWEB = bweb;
        if (addr < DepthB) model_b[addr] = (model_b[addr] & bweb) | (d & ~bweb);
    endtask

    task automatic test_reset();
        clear_ab();
        bus_a.AA = '0; bus_a.AB = '0; bus_a.D = '0; bus_a.BWEB = '1;
        bus_b.AA = '0; bus_b.AB = '0; bus_b.D = '0; bus_b.BWEB = '1;
        rstb_a = 1'b0;
        rstb_b = 1'b0;
        tick();
        tick();
        n_checks += 4;
        if (bus_a.Q !== '0) begin n_fail++; $display("FAIL reset_q_a: Q=%h want 0", bus_a.Q); end
        if (bus_a.INIT_DONE !== 1'b0) begin
            n_fail++; $display("FAIL reset_done_a: INIT_DONE=%b want 0", bus_a.INIT_DONE);
        end
        if (bus_b.Q !== '0) begin n_fail++; $display("FAIL reset_q_b: Q=%h want 0", bus_b.Q); end
        if (bus_b.INIT_DONE !== 1'b0) begin
            n_fail++; $display("FAIL reset_done_b: INIT_DONE=%b want 0", bus_b.INIT_DONE);
        end
    endtask

    task automatic test_init_sweep();
        int rise_a = -1;
        int rise_b = -1;
        int bad_q  = 0;
        rstb_a = 1'b1;
        rstb_b = 1'b1;
        bus_a.REB = 1'b0; bus_a.AB = AddW'(3);
        bus_b.REB = 1'b0; bus_b.AB = AddW'(3);
        for (int t = 1; t <= int'(DepthA) + 4; t++) begin
            tick();
            if (bus_a.INIT_DONE === 1'b1 && rise_a < 0) rise_a = t;
            if (bus_b.INIT_DONE === 1'b1 && rise_b < 0) rise_b = t;
            if (bus_a.INIT_DONE !== 1'b1 && bus_a.Q !== '0) bad_q++;
            if (bus_b.INIT_DONE !== 1'b1 && bus_b.Q !== '0) bad_q++;
        end
        n_checks += 3;
        if (rise_a != int'(DepthA)) begin
            n_fail++; $display("FAIL init_rise_a: rose at %0d want %0d", rise_a, DepthA);
        end
        if (rise_b != int'(DepthB)) begin
            n_fail++; $display("FAIL init_rise_b: rose at %0d want %0d", rise_b, DepthB);
        end
        if (bad_q != 0) begin
            n_fail++; $display("FAIL init_q_zero: %0d nonzero Q samples want 0", bad_q);
        end
        clear_ab();
        tick();
        tick();
        for (int i = 0; i < int'(DepthA); i++) model_a[i] = '0;
        for (int i = 0; i < int'(DepthB); i++) model_b[i] = '0;
        for (int a = 0; a < int'(DepthA); a++) begin
            clear_ab();
            rd_a(a);
            tick();
            while (sb_a.size() > 0 && sb_a[0].due == cyc) begin
                e = sb_a.pop_front();
                n_checks++;
                if (bus_a.Q !== e.data) begin
                    n_fail++; $display("FAIL sweep_read a=%0d: Q=%h want %h", a, bus_a.Q, e.data);
                end
            end
        end
        clear_ab();
    endtask

    task automatic test_masked_write();
        clear_ab();
        wr_a(5, '1, '0);
        tick();
        clear_ab();
        wr_a(5, '0, 64'hFFFF_FFFF_0000_0000);
        tick();
        clear_ab();
        rd_a(5);
        tick();
        clear_ab();
        while (sb_a.size() > 0 && sb_a[0].due == cyc) begin
            e = sb_a.pop_front();
            n_checks++;
            if (bus_a.Q !== e.data || bus_a.Q !== 64'hFFFF_FFFF_0000_0000) begin
                n_fail++; $display("FAIL masked_write: Q=%h want %h", bus_a.Q, e.data);
            end
        end
    endtask

    task automatic test_collision();
        clear_ab();
        wr_a(7, 64'hAA, '0);
        tick();
        for (int step = 0; step < 2; step++) begin
            clear_ab();
            rd_a(7);
            if (step == 0) wr_a(7, 64'h55, '0);
            tick();
            while (sb_a.size() > 0 && sb_a[0].due == cyc) begin
                e = sb_a.pop_front();
                n_checks++;
                if (bus_a.Q !== e.data) begin
                    n_fail++; $display("FAIL collision step%0d: Q=%h want %h", step, bus_a.Q, e.data);
                end
            end
        end
        clear_ab();
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 40; i++) begin
            clear_ab();
            if ($urandom_range(0, 3) != 0) rd_a($urandom_range(0, 15));
            if ($urandom_range(0, 1) != 0)
                wr_a($urandom_range(0, 15), {$urandom, $urandom}, {$urandom, $urandom});
            tick();
            while (sb_a.size() > 0 && sb_a[0].due == cyc) begin
                e = sb_a.pop_front();
                n_checks++;
                if (bus_a.Q !== e.data) begin
                    n_fail++; $display("FAIL random_rw i=%0d: Q=%h want %h", i, bus_a.Q, e.data);
                end
            end
        end
        clear_ab();
    endtask

    task automatic test_back_to_back();
        logic [Bits-1:0] prev;
        int              changes;
        for (int i = 1; i <= 4; i++) begin
            clear_ab();
            wr_b(i, 64'(10 + i), '0);
            tick();
        end
        for (int i = 1; i <= 5; i++) begin
            clear_ab();
            if (i <= 4) rd_b(i);
            tick();
            while (sb_b.size() > 0 && sb_b[0].due == cyc) begin
                e = sb_b.pop_front();
                n_checks++;
                if (bus_b.Q !== e.data) begin
                    n_fail++; $display("FAIL b2b edge%0d: Q=%h want %h", i, bus_b.Q, e.data);
                end
            end
        end
`ifdef SRAM_MODEL_RANDOM_IDLE_EN
        changes = 0;
        prev    = bus_b.Q;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus_b.Q !== prev) changes++;
            prev = bus_b.Q;
        end
        n_checks++;
        if (changes == 0) begin
            n_fail++; $display("FAIL idle_random: Q changed %0d times want >0", changes);
        end
`else
        prev    = '0;
        changes = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus_b.Q !== 64'd14) begin
                n_fail++; $display("FAIL idle_hold: Q=%h want %h", bus_b.Q, 64'd14);
            end
        end
`endif
    endtask

    task automatic test_out_of_range();
        clear_ab();
        wr_b(510, '1, '0);
        tick();
        for (int i = 0; i < 3; i++) begin
            clear_ab();
            if (i == 0) rd_b(510);
            tick();
            while (sb_b.size() > 0 && sb_b[0].due == cyc) begin
                e = sb_b.pop_front();
                n_checks++;
                if (bus_b.Q !== e.data) begin
                    n_fail++; $display("FAIL oor_read: Q=%h want %h", bus_b.Q, e.data);
                end
            end
        end
        for (int a = 0; a < int'(DepthB) + 2; a++) begin
            clear_ab();
            if (a < int'(DepthB)) rd_b(a);
            tick();
            while (sb_b.size() > 0 && sb_b[0].due == cyc) begin
                e = sb_b.pop_front();
                n_checks++;
                if (bus_b.Q !== e.data) begin
                    n_fail++; $display("FAIL oor_unchanged a=%0d: Q=%h want %h", a, bus_b.Q, e.data);
                end
            end
        end
        clear_ab();
    endtask

    task automatic test_reset_mid();
        int rise = -1;
        // Read of addr 1 (holds 11) in flight on dut_b when reset lands.
        clear_ab();
        bus_b.REB = 1'b0;
        bus_b.AB  = AddW'(1);
        tick();
        clear_ab();
        rstb_b = 1'b0;
        tick();
        n_checks += 2;
        if (bus_b.Q !== '0) begin n_fail++; $display("FAIL inflight_q: Q=%h want 0", bus_b.Q); end
        if (bus_b.INIT_DONE !== 1'b0) begin
            n_fail++; $display("FAIL inflight_done: INIT_DONE=%b want 0", bus_b.INIT_DONE);
        end
        rstb_a = 1'b0;
        tick();
        rstb_a = 1'b1;
        rstb_b = 1'b1;
        for (int t = 0; t < 200; t++) tick();
        rstb_a = 1'b0;
        tick();
        n_checks += 2;
        if (bus_a.Q !== '0) begin n_fail++; $display("FAIL midsweep_q: Q=%h want 0", bus_a.Q); end
        if (bus_a.INIT_DONE !== 1'b0) begin
            n_fail++; $display("FAIL midsweep_done: INIT_DONE=%b want 0", bus_a.INIT_DONE);
        end
        rstb_a = 1'b1;
        for (int t = 1; t <= 600 && rise < 0; t++) begin
            tick();
            if (bus_a.INIT_DONE === 1'b1) rise = t;
        end
        n_checks++;
        if (rise != int'(DepthA)) begin
            n_fail++; $display("FAIL midsweep_rise: rose at %0d want %0d", rise, DepthA);
        end
        for (int i = 0; i < int'(DepthA); i++) model_a[i] = '0;
        for (int i = 0; i < int'(DepthB); i++) model_b[i] = '0;
        for (int i = 0; i < 3; i++) begin
            clear_ab();
            if (i == 0) begin rd_a(5); rd_b(1); end
            tick();
            while (sb_a.size() > 0 && sb_a[0].due == cyc) begin
                e = sb_a.pop_front();
                n_checks++;
                if (bus_a.Q !== e.data) begin
                    n_fail++; $display("FAIL recleared_a: Q=%h want %h", bus_a.Q, e.data);
                end
            end
            while (sb_b.size() > 0 && sb_b[0].due == cyc) begin
                e = sb_b.pop_front();
                n_checks++;
                if (bus_b.Q !== e.data) begin
                    n_fail++; $display("FAIL recleared_b: Q=%h want %h", bus_b.Q, e.data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_masked_write();
        test_collision();
        test_random_traffic();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        n_checks++;
        if (sb_a.size() + sb_b.size() != 0) begin
            n_fail++; $display("FAIL sb_empty: %0d pending want 0", sb_a.size() + sb_b.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end
endmodule
